// File: rtl/step_counter_pkg.sv
// step_counter_pkg: shared encodings for the LED step counter.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
package step_counter_pkg;

  // Bit positions inside the BTTN bus.
  localparam int BTN_STEP = 0;
  localparam int BTN_MODE = 1;
  localparam int BTN_CLR  = 2;
  localparam int BTN_DIR  = 3;
  localparam int NUM_BTN  = 4;

  // Bit positions inside the ACT_LED bus.
  localparam int ACT_HB   = 0;
  localparam int ACT_MODE = 1;
  localparam int ACT_DIR  = 2;

  typedef enum logic {
    MODE_MANUAL = 1'b0,
    MODE_AUTO   = 1'b1
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  function automatic mode_e flip_mode(input mode_e m);
    return (m == MODE_AUTO) ? MODE_MANUAL : MODE_AUTO;
  endfunction

  function automatic dir_e flip_dir(input dir_e d);
    return (d == DIR_DOWN) ? DIR_UP : DIR_DOWN;
  endfunction

endpackage

// File: rtl/step_counter_pb_filter.sv
// pb_filter: 2-flop synchroniser plus sample-count debounce for one push button.
// Latency: press pulse 2 + (DB_SAMPLES-1..DB_SAMPLES strobe periods) + 1 cycles after the raw edge.
// Backpressure: none; press is a one-cycle pulse the consumer must take that cycle.
// Ports: CLK, RST_N, strobe (shared sample enable), raw (asynchronous button),
//        level (debounced stable state), press (one-cycle pulse on a stable 0->1 change).
module pb_filter #(
  parameter int DB_SAMPLES = 4
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic strobe,
  input  logic raw,
  output logic level,
  output logic press
);

  // Counts samples that disagree with the stable state; 0..DB_SAMPLES-1.
  localparam int CW = (DB_SAMPLES > 2) ? $clog2(DB_SAMPLES) : 1;

  logic [1:0]    sync_q;
  logic          sample;
  logic [CW-1:0] agree_q;
  logic          level_q;
  logic          level_dly_q;
  logic          press_q;

  assign sample = sync_q[1];
  assign level  = level_q;
  assign press  = press_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync_q      <= 2'b00;
      agree_q     <= '0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      press_q     <= 1'b0;
    end else begin
      sync_q      <= {sync_q[0], raw};
      level_dly_q <= level_q;
      press_q     <= level_q & ~level_dly_q;

      if (strobe) begin
        // The state is binary, so "samples agree with each other and differ
        // from the stable state" reduces to a run of samples != level_q.
        if (sample == level_q) begin
          agree_q <= '0;
        end else if (agree_q == CW'(DB_SAMPLES - 1)) begin
          level_q <= sample;
          agree_q <= '0;
        end else begin
          agree_q <= agree_q + CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/step_counter.sv
// step_counter: single-clock LED up/down counter stepped by a prescaler tick or a debounced button.
// Latency: tick or press pulse to LEDS/COUNT_EVT/WRAP is 1 cycle; all outputs registered.
// Backpressure: none; free-running, events are consumed the cycle they occur.
// Ports: CLK, RST_N (async, active-low), BTTN[3:0] raw buttons (step, mode, clear, dir),
//        LEDS count, ACT_LED {dir, mode, heartbeat}, COUNT_EVT / WRAP one-cycle pulses.
module step_counter
  import step_counter_pkg::*;
#(
  parameter int WIDTH      = 10,
  parameter int PRESCALE   = 23,
  parameter int DB_BITS    = 4,
  parameter int DB_SAMPLES = 4,
  parameter int SATURATE   = 0
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [3:0]       BTTN,
  output logic [WIDTH-1:0] LEDS,
  output logic [2:0]       ACT_LED,
  output logic             COUNT_EVT,
  output logic             WRAP
);

  logic [PRESCALE-1:0] pre_q;
  logic                tick;
  logic [DB_BITS-1:0]  db_q;
  logic                db_strobe;

  logic [NUM_BTN-1:0]  btn_level;
  logic [NUM_BTN-1:0]  btn_press;

  mode_e               mode_q;
  dir_e                dir_q;
  logic                hb_q;

  logic [WIDTH-1:0]    cnt_q;
  logic [WIDTH-1:0]    cnt_d;
  logic [WIDTH-1:0]    cnt_step;
  logic                evt_q;
  logic                evt_d;
  logic                wrap_q;
  logic                wrap_d;
  logic                step_req;
  logic                at_limit;

  // Only the clear button is used as a level; it has no press function.
  logic                unused_btn;
  assign unused_btn = ^{btn_level[BTN_STEP], btn_level[BTN_MODE],
                        btn_level[BTN_DIR], btn_press[BTN_CLR]};

  // Both strobes are enables only: pulses while the free-running counter is all ones.
  assign tick      = &pre_q;
  assign db_strobe = &db_q;

  for (genvar b = 0; b < NUM_BTN; b++) begin : g_btn
    pb_filter #(
      .DB_SAMPLES(DB_SAMPLES)
    ) u_pb (
      .CLK   (CLK),
      .RST_N (RST_N),
      .strobe(db_strobe),
      .raw   (BTTN[b]),
      .level (btn_level[b]),
      .press (btn_press[b])
    );
  end

  // Counter datapath. mode_q/dir_q are the pre-toggle values, so a step in
  // the same cycle as a mode or direction press uses the old settings.
  always_comb begin
    step_req = (mode_q == MODE_AUTO) ? tick : btn_press[BTN_STEP];
    at_limit = (dir_q == DIR_UP) ? (cnt_q == '1) : (cnt_q == '0);
    cnt_step = (dir_q == DIR_UP) ? (cnt_q + WIDTH'(1)) : (cnt_q - WIDTH'(1));

    cnt_d  = cnt_q;
    evt_d  = 1'b0;
    wrap_d = 1'b0;

    if (btn_level[BTN_CLR]) begin
      // Clear wins over any step and swallows its COUNT_EVT/WRAP.
      cnt_d = '0;
      evt_d = (cnt_q != '0);
    end else if (step_req) begin
      wrap_d = at_limit;
      if (!at_limit || (SATURATE == 0)) begin
        cnt_d = cnt_step;
        evt_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pre_q  <= '0;
      db_q   <= '0;
      hb_q   <= 1'b0;
      mode_q <= MODE_MANUAL;
      dir_q  <= DIR_UP;
      cnt_q  <= '0;
      evt_q  <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      pre_q  <= pre_q + PRESCALE'(1);
      db_q   <= db_q + DB_BITS'(1);
      cnt_q  <= cnt_d;
      evt_q  <= evt_d;
      wrap_q <= wrap_d;
      if (tick) begin
        hb_q <= ~hb_q;
      end
      if (btn_press[BTN_MODE]) begin
        mode_q <= flip_mode(mode_q);
      end
      if (btn_press[BTN_DIR]) begin
        dir_q <= flip_dir(dir_q);
      end
    end
  end

  assign LEDS      = cnt_q;
  assign COUNT_EVT = evt_q;
  assign WRAP      = wrap_q;

  always_comb begin
    ACT_LED           = '0;
    ACT_LED[ACT_HB]   = hb_q;
    ACT_LED[ACT_MODE] = (mode_q == MODE_AUTO);
    ACT_LED[ACT_DIR]  = (dir_q == DIR_DOWN);
  end

endmodule

// File: tb/tb_step_counter.sv
// tb_step_counter: random and directed stimulus on a wrapping and a saturating
// step_counter side by side, checked against an event-level behavioural model.
// Ticks land every 8 cycles after reset release; button stimulus is phased so
// each debounced action lands strictly between ticks.
module tb_step_counter;
  import step_counter_pkg::*;

  localparam int W      = 4;
  localparam int PS     = 3;
  localparam int DBB    = 1;
  localparam int DBS    = 3;
  localparam int PERIOD = 1 << PS;
  localparam int MAXV   = (1 << W) - 1;
  localparam int K_CLR_ON  = 16;
  localparam int K_CLR_OFF = 32;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic [3:0]   bttn  = 4'b0000;
  logic [W-1:0] leds [2];
  logic [2:0]   act  [2];
  logic         evt  [2];
  logic         wrp  [2];

  always #5 clk = ~clk;

  step_counter #(.WIDTH(W), .PRESCALE(PS), .DB_BITS(DBB), .DB_SAMPLES(DBS), .SATURATE(0)) dut_wrap (
    .CLK(clk), .RST_N(rst_n), .BTTN(bttn), .LEDS(leds[0]), .ACT_LED(act[0]),
    .COUNT_EVT(evt[0]), .WRAP(wrp[0]));

  step_counter #(.WIDTH(W), .PRESCALE(PS), .DB_BITS(DBB), .DB_SAMPLES(DBS), .SATURATE(1)) dut_sat (
    .CLK(clk), .RST_N(rst_n), .BTTN(bttn), .LEDS(leds[1]), .ACT_LED(act[1]),
    .COUNT_EVT(evt[1]), .WRAP(wrp[1]));

  // Pulse counters observed from the DUTs, cleared by reset.
  int obs_evt [2];
  int obs_wrap[2];
  always @(negedge clk or negedge rst_n) begin
    for (int s = 0; s < 2; s++) begin
      if (!rst_n) begin
        obs_evt[s]  <= 0;
        obs_wrap[s] <= 0;
      end else begin
        if (evt[s]) obs_evt[s]  <= obs_evt[s] + 1;
        if (wrp[s]) obs_wrap[s] <= obs_wrap[s] + 1;
      end
    end
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  // Reference model.
  int m_cnt [2];
  int m_evt [2];
  int m_wrap[2];
  bit m_pe  [2];
  bit m_pw  [2];
  bit m_mode, m_dir, m_hb, m_clr;
  int t;
  int pend_due [$];
  int pend_kind[$];

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      m_cnt[s] = 0; m_evt[s] = 0; m_wrap[s] = 0; m_pe[s] = 0; m_pw[s] = 0;
    end
    m_mode = 0; m_dir = 0; m_hb = 0; m_clr = 0; t = 0;
    pend_due.delete();
    pend_kind.delete();
  endtask

  task automatic model_step();
    for (int s = 0; s < 2; s++) begin
      int nxt;
      bit lim;
      nxt = m_dir ? m_cnt[s] - 1 : m_cnt[s] + 1;
      lim = (nxt < 0) || (nxt > MAXV);
      if (lim) begin
        m_wrap[s]++;
        m_pw[s] = 1;
      end
      if (!lim || s == 0) begin
        m_cnt[s] = (nxt + MAXV + 1) % (MAXV + 1);
        m_evt[s]++;
        m_pe[s] = 1;
      end
    end
  endtask

  task automatic apply(input int kind);
    if (kind == K_CLR_ON) begin
      for (int s = 0; s < 2; s++) if (m_cnt[s] != 0) begin
        m_cnt[s] = 0;
        m_evt[s]++;
      end
      m_clr = 1;
    end else if (kind == K_CLR_OFF) begin
      m_clr = 0;
    end else begin
      if (((kind >> BTN_STEP) & 1) == 1 && !m_mode && !m_clr) model_step();
      if (((kind >> BTN_MODE) & 1) == 1) m_mode = !m_mode;
      if (((kind >> BTN_DIR) & 1) == 1) m_dir = !m_dir;
    end
  endtask

  task automatic sched(input int due, input int kind);
    pend_due.push_back(due);
    pend_kind.push_back(kind);
  endtask

  task automatic step_cycle();
    @(posedge clk);
    #1;
    t++;
    for (int s = 0; s < 2; s++) begin
      m_pe[s] = 0;
      m_pw[s] = 0;
    end
    if (t % PERIOD == 0) begin
      m_hb = !m_hb;
      if (m_mode && !m_clr) model_step();
    end
    for (int i = pend_due.size() - 1; i >= 0; i--) begin
      if (pend_due[i] == t) begin
        apply(pend_kind[i]);
        pend_due.delete(i);
        pend_kind.delete(i);
      end
    end
  endtask

  task automatic run(input int n);
    repeat (n) step_cycle();
  endtask

  task automatic align(input int k);
    while (t % PERIOD != k) step_cycle();
  endtask

  function automatic int exp_act();
    return (int'(m_dir) << 2) | (int'(m_mode) << 1) | int'(m_hb);
  endfunction

  task automatic check_state(input string tag);
    for (int s = 0; s < 2; s++) begin
      chk($sformatf("%s.leds%0d", tag, s), int'(leds[s]), m_cnt[s]);
      chk($sformatf("%s.nevt%0d", tag, s), obs_evt[s], m_evt[s]);
      chk($sformatf("%s.nwrap%0d", tag, s), obs_wrap[s], m_wrap[s]);
      chk($sformatf("%s.act%0d", tag, s), int'(act[s]), exp_act());
    end
  endtask

  // Cycle-exact check, used only right after a tick edge.
  task automatic check_pulse(input string tag);
    for (int s = 0; s < 2; s++) begin
      chk($sformatf("%s.leds%0d", tag, s), int'(leds[s]), m_cnt[s]);
      chk($sformatf("%s.evt%0d", tag, s), int'(evt[s]), int'(m_pe[s]));
      chk($sformatf("%s.wrap%0d", tag, s), int'(wrp[s]), int'(m_pw[s]));
      chk($sformatf("%s.hb%0d", tag, s), int'(act[s][0]), int'(m_hb));
    end
  endtask

  task automatic check_zero(input string tag);
    for (int s = 0; s < 2; s++) begin
      chk($sformatf("%s.leds%0d", tag, s), int'(leds[s]), 0);
      chk($sformatf("%s.act%0d", tag, s), int'(act[s]), 0);
      chk($sformatf("%s.evt%0d", tag, s), int'(evt[s]), 0);
      chk($sformatf("%s.wrap%0d", tag, s), int'(wrp[s]), 0);
    end
  endtask

  // Raise just after a tick edge: the action lands 9-10 cycles later, between ticks.
  task automatic press(input int mask);
    align(0);
    bttn = bttn | 4'(mask);
    sched(t + 10, mask);
    run(12);
    bttn = bttn & ~4'(mask);
    run(12);
  endtask

  task automatic clear_on();
    align(2);
    bttn[BTN_CLR] = 1'b1;
    sched(t + 9, K_CLR_ON);
    run(12);
  endtask

  task automatic clear_off();
    align(2);
    bttn[BTN_CLR] = 1'b0;
    sched(t + 9, K_CLR_OFF);
    run(12);
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;

    // Idle in manual mode: only the heartbeat moves.
    repeat (12) begin
      run(PERIOD);
      check_pulse("idle");
    end
    run(4);
    check_state("idle_end");

    // Three manual steps, then a glitch too short to qualify.
    repeat (3) press(1 << BTN_STEP);
    align(4);
    check_state("step3");
    align(0);
    bttn[BTN_STEP] = 1'b1;
    run(3);
    bttn[BTN_STEP] = 1'b0;
    run(24);
    align(4);
    check_state("glitch");

    // Clear to 0, then auto count up through the wrap.
    clear_on();
    clear_off();
    align(4);
    check_state("clr_manual");
    press(1 << BTN_MODE);
    repeat (17) begin
      run(1);
      align(0);
      check_pulse("auto_up");
    end

    // Clear held across ticks in auto mode, direction flipped during the hold.
    clear_on();
    repeat (2) begin
      run(1);
      align(0);
      check_pulse("clr_hold");
    end
    press(1 << BTN_DIR);
    clear_off();
    repeat (3) begin
      run(1);
      align(0);
      check_pulse("down");
    end
    align(4);
    check_state("down_end");

    // Back to manual, direction up, then step and mode pressed together.
    press(1 << BTN_MODE);
    press(1 << BTN_DIR);
    press((1 << BTN_STEP) | (1 << BTN_MODE));
    align(4);
    check_state("step_mode");

    // Random operation mix.
    repeat (24) begin
      case ($urandom_range(0, 5))
        0: press(1 << BTN_STEP);
        1: press(1 << BTN_MODE);
        2: press(1 << BTN_DIR);
        3: press((1 << BTN_STEP) | (1 << BTN_DIR));
        4: begin
          clear_on();
          run($urandom_range(0, 20));
          clear_off();
        end
        default: run($urandom_range(1, 30));
      endcase
      align(4);
      check_state("rand");
    end

    // Reset in the middle of a debounce, with the button still held afterwards.
    if (!m_mode) press(1 << BTN_MODE);
    if (!m_dir) press(1 << BTN_DIR);
    run(3 * PERIOD);
    align(0);
    bttn = 4'b0000;
    bttn[BTN_STEP] = 1'b1;
    run(4);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_zero("async_rst");
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    sched(10, 1 << BTN_STEP);
    run(8);
    check_state("requalify");
    run(4);
    bttn[BTN_STEP] = 1'b0;
    run(12);
    align(4);
    check_state("after_rst_step");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
